// File: rtl/ved_seq_32x32.sv
// ved_seq_32x32: sequential 32x32 unsigned multiplier built on one ved_16x16.
// Four partial-product passes (aL*bL, aH*bL, aL*bH, aH*bH) are accumulated
// into a 64-bit product. Operands and result use valid/ready handshakes.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready only in IDLE)
//   a, b                    32-bit unsigned operands, sampled on accept
//   out_valid/out_ready     result handshake
//   product                 64-bit result, held stable through DONE
//   busy                    high in CALC and DONE
//   pass                    current pass index (debug), 0 outside CALC
// Parameter REG_MUL: 1 registers the 16x16 product before accumulation.

// 2x2 Vedic multiplier cell.
module ved_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  logic cross_lo;
  logic cross_hi;
  logic carry;
  logic top;

  assign cross_lo = a[1] & b[0];
  assign cross_hi = a[0] & b[1];
  assign carry    = cross_lo & cross_hi;
  assign top      = a[1] & b[1];
  assign p[0]     = a[0] & b[0];
  assign p[1]     = cross_lo ^ cross_hi;
  assign p[2]     = top ^ carry;
  assign p[3]     = top & carry;
endmodule

// 4x4 from four 2x2 cells.
module ved_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [3:0] q0, q1, q2, q3;

  ved_2x2 u_q0 (.a(a[1:0]), .b(b[1:0]), .p(q0));
  ved_2x2 u_q1 (.a(a[3:2]), .b(b[1:0]), .p(q1));
  ved_2x2 u_q2 (.a(a[1:0]), .b(b[3:2]), .p(q2));
  ved_2x2 u_q3 (.a(a[3:2]), .b(b[3:2]), .p(q3));

  assign p = {4'b0, q0} + ({4'b0, q1} << 2) + ({4'b0, q2} << 2) + {q3, 4'b0};
endmodule

// 8x8 from four 4x4 blocks.
module ved_8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  logic [7:0] q0, q1, q2, q3;

  ved_4x4 u_q0 (.a(a[3:0]), .b(b[3:0]), .p(q0));
  ved_4x4 u_q1 (.a(a[7:4]), .b(b[3:0]), .p(q1));
  ved_4x4 u_q2 (.a(a[3:0]), .b(b[7:4]), .p(q2));
  ved_4x4 u_q3 (.a(a[7:4]), .b(b[7:4]), .p(q3));

  assign p = {8'b0, q0} + ({8'b0, q1} << 4) + ({8'b0, q2} << 4) + {q3, 8'b0};
endmodule

// 16x16 from four 8x8 blocks.
module ved_16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  logic [15:0] q0, q1, q2, q3;

  ved_8x8 u_q0 (.a(a[7:0]),  .b(b[7:0]),  .p(q0));
  ved_8x8 u_q1 (.a(a[15:8]), .b(b[7:0]),  .p(q1));
  ved_8x8 u_q2 (.a(a[7:0]),  .b(b[15:8]), .p(q2));
  ved_8x8 u_q3 (.a(a[15:8]), .b(b[15:8]), .p(q3));

  assign p = {16'b0, q0} + ({16'b0, q1} << 8) + ({16'b0, q2} << 8) + {q3, 16'b0};
endmodule

module ved_seq_32x32 #(
  parameter bit REG_MUL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] product,
  output logic        busy,
  output logic [1:0]  pass
);
  localparam int unsigned OP_W   = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned ACC_W  = 64;
  localparam int unsigned STEP_W = 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [OP_W-1:0]     a_q;
  logic [OP_W-1:0]     b_q;
  logic [ACC_W-1:0]    acc;
  logic [STEP_W-1:0]   step;
  logic [1:0]          pass_d;
  logic [OP_W-1:0]     pp_q;

  logic [HALF_W-1:0]   mul_a;
  logic [HALF_W-1:0]   mul_b;
  logic [OP_W-1:0]     pp;
  logic [OP_W-1:0]     acc_pp;
  logic [1:0]          acc_pass;
  logic [ACC_W-1:0]    acc_term;
  logic [ACC_W-1:0]    acc_sum;
  logic                acc_en;
  logic                last;

  // pass bit 0 picks the high half of a, bit 1 the high half of b.
  assign mul_a = pass[0] ? a_q[31:16] : a_q[15:0];
  assign mul_b = pass[1] ? b_q[31:16] : b_q[15:0];

  ved_16x16 u_mul (.a(mul_a), .b(mul_b), .p(pp));

  // Shifted partial product and next accumulator value. With REG_MUL the
  // product and its pass index are one cycle behind, so step 0 has nothing
  // to accumulate and one extra drain step finishes the last pass.
  always_comb begin
    acc_pp   = REG_MUL ? pp_q : pp;
    acc_pass = REG_MUL ? pass_d : pass;
    acc_term = '0;
    case (acc_pass)
      2'd0:    acc_term = {32'b0, acc_pp};
      2'd1,
      2'd2:    acc_term = {16'b0, acc_pp, 16'b0};
      default: acc_term = {acc_pp, 32'b0};
    endcase
    acc_sum = acc + acc_term;
    acc_en  = REG_MUL ? (step != 3'd0) : 1'b1;
    last    = (step == (REG_MUL ? 3'd4 : 3'd3));
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      step      <= '0;
      pass_d    <= '0;
      pp_q      <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      product   <= '0;
      busy      <= 1'b0;
      pass      <= '0;
    end else begin
      pass_d <= pass;
      pp_q   <= pp;
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            state    <= CALC;
            a_q      <= a;
            b_q      <= b;
            acc      <= '0;
            step     <= '0;
            pass     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          if (acc_en) begin
            acc <= acc_sum;
          end
          step <= step + 3'd1;
          // pass saturates at 3 so it holds through the drain cycle
          pass <= (step >= 3'd2) ? 2'd3 : 2'(step + 3'd1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            product   <= acc_sum;
            pass      <= '0;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ved_seq_32x32.sv
// Testbench for ved_seq_32x32: instance 0 with REG_MUL=0, instance 1 with
// REG_MUL=1. Directed vectors with hand-computed products plus a streaming
// run checked against a 64-bit reference multiply.
module tb_ved_seq_32x32;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_v  [2];
  logic [31:0] a_v         [2];
  logic [31:0] b_v         [2];
  logic        out_ready_v [2];
  logic        in_ready_v  [2];
  logic        out_valid_v [2];
  logic        busy_v      [2];
  logic [63:0] product_v   [2];
  logic [1:0]  pass_v      [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ved_seq_32x32 #(.REG_MUL(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a_v[0]), .b(b_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .product(product_v[0]), .busy(busy_v[0]), .pass(pass_v[0])
  );

  ved_seq_32x32 #(.REG_MUL(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a_v[1]), .b(b_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .product(product_v[1]), .busy(busy_v[1]), .pass(pass_v[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One operation with out_ready=1; operands scrambled right after accept.
  task automatic run_op(input int s, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp, input int lat_exp);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready_v[s] && guard < 20) begin
      tick;
      guard++;
    end
    check("ready_before_accept", 64'(in_ready_v[s]), 64'd1);
    a_v[s] = av;
    b_v[s] = bv;
    in_valid_v[s]  = 1'b1;
    out_ready_v[s] = 1'b1;
    tick;
    in_valid_v[s] = 1'b0;
    a_v[s] = $urandom;
    b_v[s] = $urandom;
    check("ready_low_after_accept", 64'(in_ready_v[s]), 64'd0);
    lat = 0;
    while (!out_valid_v[s] && lat < 20) begin
      check("busy_calc", 64'(busy_v[s]), 64'd1);
      check("pass_seq", 64'(pass_v[s]), (lat > 3) ? 64'd3 : 64'(lat));
      tick;
      lat++;
    end
    check("latency", 64'(lat), 64'(lat_exp));
    check("product", product_v[s], exp);
    check("pass_done", 64'(pass_v[s]), 64'd0);
    tick;
    check("valid_one_cycle", 64'(out_valid_v[s]), 64'd0);
    check("ready_after_handshake", 64'(in_ready_v[s]), 64'd1);
    check("busy_after_handshake", 64'(busy_v[s]), 64'd0);
  endtask

  // Result held in DONE while out_ready=0; in_valid and operands toggle.
  task automatic backpressure(input int s);
    int guard;
    a_v[s] = 32'h0001_0002;
    b_v[s] = 32'h0003_0004;
    in_valid_v[s]  = 1'b1;
    out_ready_v[s] = 1'b0;
    tick;
    in_valid_v[s] = 1'b0;
    guard = 0;
    while (!out_valid_v[s] && guard < 20) begin
      tick;
      guard++;
    end
    check("bp_reached_done", 64'(out_valid_v[s]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      in_valid_v[s] = ~in_valid_v[s];
      a_v[s] = $urandom;
      b_v[s] = $urandom;
      tick;
      check("bp_valid_held", 64'(out_valid_v[s]), 64'd1);
      check("bp_ready_low", 64'(in_ready_v[s]), 64'd0);
      check("bp_busy", 64'(busy_v[s]), 64'd1);
      check("bp_product", product_v[s], 64'h0000_0003_000A_0008);
    end
    in_valid_v[s]  = 1'b0;
    out_ready_v[s] = 1'b1;
    tick;
    check("bp_valid_drop", 64'(out_valid_v[s]), 64'd0);
    check("bp_ready_rise", 64'(in_ready_v[s]), 64'd1);
    check("bp_busy_drop", 64'(busy_v[s]), 64'd0);
  endtask

  // Back-to-back operations with in_valid=out_ready=1 throughout.
  task automatic stream(input int s, input int n, input int period);
    logic [63:0] q[$];
    int cyc;
    int last_acc;
    int n_acc;
    int n_res;
    logic accepting;
    logic [63:0] exp;
    cyc = 0;
    last_acc = 0;
    n_acc = 0;
    n_res = 0;
    a_v[s] = $urandom;
    b_v[s] = $urandom;
    in_valid_v[s]  = 1'b1;
    out_ready_v[s] = 1'b1;
    while (n_res < n && cyc < 20 * n) begin
      accepting = in_ready_v[s] && in_valid_v[s];
      if (out_valid_v[s]) begin
        exp = (q.size() > 0) ? q.pop_front() : 64'hx;
        check("stream_product", product_v[s], exp);
        n_res++;
      end
      if (accepting) begin
        q.push_back(64'(a_v[s]) * 64'(b_v[s]));
        if (n_acc > 0) check("stream_spacing", 64'(cyc - last_acc), 64'(period));
        last_acc = cyc;
        n_acc++;
      end
      tick;
      cyc++;
      if (accepting) begin
        a_v[s] = $urandom;
        b_v[s] = $urandom;
        in_valid_v[s] = (n_acc < n);
      end
    end
    check("stream_results", 64'(n_res), 64'(n));
    in_valid_v[s] = 1'b0;
    tick;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      in_valid_v[s]  = 1'b0;
      out_ready_v[s] = 1'b0;
      a_v[s] = '0;
      b_v[s] = '0;
    end
    rst_n = 1'b0;
    tick;
    tick;
    for (int s = 0; s < 2; s++) begin
      check("rst_in_ready", 64'(in_ready_v[s]), 64'd0);
      check("rst_out_valid", 64'(out_valid_v[s]), 64'd0);
      check("rst_product", product_v[s], 64'd0);
      check("rst_busy", 64'(busy_v[s]), 64'd0);
      check("rst_pass", 64'(pass_v[s]), 64'd0);
    end
    rst_n = 1'b1;
    tick;
    check("ready_after_reset", 64'(in_ready_v[0]), 64'd1);

    run_op(0, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 4);
    run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 4);
    run_op(0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 4);
    run_op(0, 32'h0000_0000, 32'hDEAD_BEEF, 64'h0000_0000_0000_0000, 4);

    backpressure(0);

    // reset while the second pass is in flight
    a_v[0] = 32'h1234_5678;
    b_v[0] = 32'h9ABC_DEF0;
    in_valid_v[0] = 1'b1;
    tick;
    in_valid_v[0] = 1'b0;
    tick;
    tick;
    check("mid_pass_before_reset", 64'(pass_v[0]), 64'd2);
    rst_n = 1'b0;
    tick;
    check("mid_rst_busy", 64'(busy_v[0]), 64'd0);
    check("mid_rst_valid", 64'(out_valid_v[0]), 64'd0);
    check("mid_rst_product", product_v[0], 64'd0);
    check("mid_rst_pass", 64'(pass_v[0]), 64'd0);
    rst_n = 1'b1;
    tick;
    run_op(0, 32'd3, 32'd5, 64'd15, 4);

    stream(0, 100, 6);

    run_op(1, 32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008, 5);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5);
    stream(1, 100, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ved_seq_32x32.md
# ved_seq_32x32

Sequential 32x32 unsigned multiplier controller. It time-multiplexes one `ved_16x16` instance over four partial-product passes and accumulates the results into a 64-bit product. Operands enter and the result leaves through valid/ready handshakes. The block is the first sequenced consumer of the Vedic multiplier hierarchy and is the template for wider multipliers that reuse it.

## Interface
- `REG_MUL`, default 0. 0: the 16x16 product is used combinationally. 1: the product is registered before accumulation, adding one cycle of latency.
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands (IDLE only)
- `a`  in  32  multiplicand, unsigned, sampled on accept
- `b`  in  32  multiplier, unsigned, sampled on accept
- `out_valid`  out  1  `product` valid
- `out_ready`  in  1  consumer takes product
- `product`  out  64  a*b, unsigned
- `busy`  out  1  high in CALC and DONE
- `pass`  out  2  current pass index, for debug; 0 outside CALC

## Operation
- States:
  - IDLE: `in_ready`=1.
  - CALC: runs passes 0..3, plus one drain cycle when `REG_MUL`=1.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE→CALC on `in_valid`&&`in_ready`. Latch `a`/`b` into internal registers and clear the accumulator.
  - CALC→DONE after the last accumulate.
  - DONE→IDLE on `out_valid`&&`out_ready`.
- Pass order and shifts (aL/aH = a[15:0]/a[31:16]; likewise for b):
  - pass 0: aL*bL, shift 0
  - pass 1: aH*bL, shift 16
  - pass 2: aL*bH, shift 16
  - pass 3: aH*bH, shift 32
- Accumulation: acc ← acc + ({32'b0, pp} << shift), 64-bit. No overflow is possible because (2^32−1)^2 < 2^64, so no carry out is kept.
- Exactly one `ved_16x16` instance is used. Its operand muxes are driven from the latched registers by `pass`, never from the live `a`/`b` ports.
- `product` is driven from the accumulator and changes only when entering DONE. It is held stable through DONE regardless of `out_ready`.
- In DONE, `in_valid` is ignored; there is no accept in the same cycle as result handoff.
- Reset (`rst_n`=0 at a clock edge) from any state:
  - state ← IDLE, in-flight operation discarded.
  - accumulator, latched operands and `product` ← 0.
  - `pass` ← 0.

## Timing
- Reset values, while `rst_n`=0 and in the cycle after the reset edge:
  - `in_ready`=0, `out_valid`=0, `product`=0, `busy`=0, `pass`=0.
  - `in_ready` rises at the first edge with `rst_n`=1.
- Accept edge E0. Passes are accumulated at edges E1..E4; with `REG_MUL`=1, at E2..E5.
- `out_valid` rises:
  - after E4 when `REG_MUL`=0 (latency 4 cycles);
  - after E5 when `REG_MUL`=1 (latency 5 cycles).
- `in_ready` falls after E0 and rises again the cycle after the output handshake edge.
- Throughput with `in_valid`=`out_ready`=1 continuously: one result per 6 cycles (`REG_MUL`=0) or 7 cycles (`REG_MUL`=1).
- `busy`=1 from the cycle after E0 through the last DONE cycle.
- `pass` holds 0,1,2,3 in the successive CALC cycles. With `REG_MUL`=1 it holds 3 through the drain cycle.
- Operand changes on `a`/`b` after E0 have no effect on the result.

## Test plan
- Reset, then a=0x00010002, b=0x00030004, `out_ready`=1 → `product`=0x0000_0003_000A_0008. `out_valid` is high for exactly 1 cycle, 4 cycles after accept.
- a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE_00000001. a=0x00010000, b=0x00010000 → 0x00000001_00000000. a=0, b=0xDEADBEEF → 0.
- Backpressure: hold `out_ready`=0 for 3 cycles in DONE and toggle `in_valid` and `a`/`b` meanwhile → `product` is stable, `out_valid` stays 1, `in_ready` stays 0, no new accept. After `out_ready`=1, `in_ready`=1 on the next cycle.
- Reset mid-op: drive `rst_n`=0 for one edge while `pass`=2 → next cycle `busy`=0, `out_valid`=0, `product`=0. A subsequent a=3, b=5 gives `product`=15.
- Streaming: `in_valid`=`out_ready`=1 with 100 random operand pairs, compared against a 64-bit reference model → all match, with accepts spaced exactly 6 cycles apart.
- `REG_MUL`=1: repeat the first and fifth scenarios → same products, latency 5, accepts 7 cycles apart.
